// File: rtl/rop3_pkg.sv
// Shared definitions for the ROP3 blit controller.
// Holds the controller FSM encoding and the named ROP3 codes.
package rop3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] ROP_BLACKNESS = 8'h00;
    localparam logic [7:0] ROP_SRCCOPY   = 8'hCC;
    localparam logic [7:0] ROP_PATCOPY   = 8'hF0;
    localparam logic [7:0] ROP_SRCINVERT = 8'h66;
    localparam logic [7:0] ROP_DSTINVERT = 8'h55;
    localparam logic [7:0] ROP_WHITENESS = 8'hFF;

endpackage

// File: rtl/rop3_tag_pipe.sv
// Tag shift register carrying {valid, addr} alongside the SRAM read and the
// rop3 core latency, so each result is written back to the address it came from.
// Ports: clk, rst (sync, active-high), in_vld/in_addr (issued read),
//        tail_vld/tail_addr (entry retiring this cycle),
//        any_vld (an entry is still upstream of the tail).
module rop3_tag_pipe
    import rop3_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          tail_vld,
    output logic [AW-1:0] tail_addr,
    output logic          any_vld
);

    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    addr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else begin
            vld[0]  <= in_vld;
            addr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= vld[i-1];
                addr[i] <= addr[i-1];
            end
        end
    end

    assign tail_vld  = vld[DEPTH-1];
    assign tail_addr = addr[DEPTH-1];

    // The tail entry retires in the current cycle, so only the stages
    // ahead of it decide whether more writes are still to come.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            any_vld = any_vld | vld[i];
        end
    end

endmodule

// File: rtl/rop3_blit_ctrl.sv
// Block-level ROP3 sequencer: reads P/S/D spans in lock-step, streams them
// through an external rop3 core and writes results back into D in place.
// Ports: clk, rst (sync, active-high); job: start, mode, len, busy, done;
//        SRAM read: rd_en, rd_addr, p/s/d_rdata; core: rop_P/S/D/Mode,
//        rop_result; D SRAM write: wr_en, wr_addr, wr_data.
module rop3_blit_ctrl
    import rop3_pkg::*;
#(
    parameter int N   = 32,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    mode,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  p_rdata,
    input  logic [N-1:0]  s_rdata,
    input  logic [N-1:0]  d_rdata,
    output logic [N-1:0]  rop_P,
    output logic [N-1:0]  rop_S,
    output logic [N-1:0]  rop_D,
    output logic [7:0]    rop_Mode,
    input  logic [N-1:0]  rop_result,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
);

    localparam int DEPTH = 1 + LAT;

    state_t        state;
    logic [AW:0]   len_q;
    logic [AW:0]   last_idx;
    logic          last_rd;
    logic          tail_vld;
    logic          any_vld;
    logic [AW-1:0] tail_addr;

    // len is at least 1 whenever RUN is active, so last_idx never underflows
    // there; len = 2^AW gives last_idx = 2^AW-1 and the counter never wraps.
    assign last_idx = len_q - {{AW{1'b0}}, 1'b1};
    assign last_rd  = ({1'b0, rd_addr} == last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rop_Mode <= 8'h00;
            len_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rop_Mode <= mode;
                        len_q    <= len;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            state <= ST_RUN;
                            rd_en <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_rd) begin
                        state <= ST_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!any_vld) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0 lines up with the SRAM data cycle, the rest with the core.
    rop3_tag_pipe #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (rd_en),
        .in_addr   (rd_addr),
        .tail_vld  (tail_vld),
        .tail_addr (tail_addr),
        .any_vld   (any_vld)
    );

    assign rop_P   = p_rdata;
    assign rop_S   = s_rdata;
    assign rop_D   = d_rdata;
    assign wr_en   = tail_vld;
    assign wr_addr = tail_addr;
    assign wr_data = rop_result;

endmodule

// File: tb/tb_rop3_blit_ctrl.sv
// Bench for rop3_blit_ctrl with behavioural SRAMs, a 2-cycle rop3 core model
// and a span-level golden model of the D memory.
module tb_rop3_blit_ctrl;
    import rop3_pkg::*;

    localparam int N   = 32;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int W   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    mode = 8'h00;
    logic [AW:0]   len = '0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [N-1:0]  p_rdata, s_rdata, d_rdata;
    logic [N-1:0]  rop_P, rop_S, rop_D, rop_result, wr_data;
    logic [7:0]    rop_Mode;

    logic [N-1:0]  pm [W];
    logic [N-1:0]  sm [W];
    logic [N-1:0]  dm [W];
    logic [N-1:0]  dn [W];
    logic [N-1:0]  gm [W];
    logic          ld = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int j_busy, j_done, j_done_at, j_done_busy, j_rd, j_wr;
    int j_first_wr, j_last_wr, j_order, j_mode_bad, j_aborted;
    int j_post_wr, j_post_done, j_first_rd_abs, j_last_wr_abs;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rop3_blit_ctrl #(.N(N), .AW(AW), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .p_rdata    (p_rdata),
        .s_rdata    (s_rdata),
        .d_rdata    (d_rdata),
        .rop_P      (rop_P),
        .rop_S      (rop_S),
        .rop_D      (rop_D),
        .rop_Mode   (rop_Mode),
        .rop_result (rop_result),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Synchronous-read SRAMs; D also accepts a bulk preload from the bench.
    always @(posedge clk) begin
        if (rd_en) begin
            p_rdata <= pm[rd_addr];
            s_rdata <= sm[rd_addr];
            d_rdata <= dm[rd_addr];
        end
        if (ld) begin
            for (int i = 0; i < W; i++) dm[i] <= dn[i];
        end else if (wr_en) begin
            dm[wr_addr] <= wr_data;
        end
    end

    // rop3 core: registered inputs, registered output.
    function automatic logic [N-1:0] core_fn(input logic [7:0] m,
        input logic [N-1:0] p, input logic [N-1:0] s, input logic [N-1:0] d);
        logic [N-1:0] r;
        for (int b = 0; b < N; b++) r[b] = m[{p[b], s[b], d[b]}];
        return r;
    endfunction

    logic [N-1:0] cp, cs, cd;
    logic [7:0]   cm;
    always @(posedge clk) begin
        cp <= rop_P;
        cs <= rop_S;
        cd <= rop_D;
        cm <= rop_Mode;
        rop_result <= core_fn(cm, cp, cs, cd);
    end

    // Golden: sum of the minterms selected by the ROP code.
    function automatic logic [N-1:0] ref_rop(input logic [7:0] m,
        input logic [N-1:0] p, input logic [N-1:0] s, input logic [N-1:0] d);
        logic [N-1:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            if (m[k])
                acc = acc | ((k[2] ? p : ~p) & (k[1] ? s : ~s) & (k[0] ? d : ~d));
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic golden(input logic [7:0] m, input int l);
        for (int a = 0; a < l; a++) gm[a] = ref_rop(m, pm[a], sm[a], gm[a]);
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < W; i++) chk(tag, 64'(dm[i]), 64'(gm[i]));
    endtask

    task automatic preload();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        for (int i = 0; i < W; i++) gm[i] = dn[i];
    endtask

    task automatic fill_rand();
        for (int i = 0; i < W; i++) begin
            pm[i] = $urandom;
            sm[i] = $urandom;
            dn[i] = $urandom;
        end
        preload();
    endtask

    // Runs one job; start is high in cycle k=0. spur_at re-pulses start with
    // mode 00 mid-job, abort_rd asserts rst while that address is read.
    task automatic run_job(input logic [7:0] m, input logic [AW:0] l,
        input int spur_at, input int abort_rd);
        int k;
        bit fin;
        j_busy = 0; j_done = 0; j_done_at = -1; j_done_busy = 0;
        j_rd = 0; j_wr = 0; j_first_wr = -1; j_last_wr = -1; j_order = 0;
        j_mode_bad = 0; j_aborted = 0; j_post_wr = 0; j_post_done = 0;
        j_first_rd_abs = -1; j_last_wr_abs = -1;
        @(negedge clk);
        start = 1'b1; mode = m; len = l;
        k = 0; fin = 0;
        while (!fin && k < 400) begin
            if (busy) j_busy++;
            if (busy && k >= 1 && rop_Mode !== m) j_mode_bad++;
            if (rd_en) begin
                if (j_first_rd_abs < 0) j_first_rd_abs = cyc;
                if (rd_addr != AW'(j_rd)) j_order++;
                j_rd++;
            end
            if (wr_en) begin
                if (j_first_wr < 0) j_first_wr = k;
                j_last_wr = k;
                j_last_wr_abs = cyc;
                if (wr_addr != AW'(j_wr)) j_order++;
                j_wr++;
            end
            if (done) begin
                j_done++;
                j_done_at = k;
                if (busy) j_done_busy++;
                fin = 1;
            end
            if (!fin && abort_rd >= 0 && rd_en && rd_addr == AW'(abort_rd)) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_wr_en", 64'(wr_en), 64'd0);
                chk("abort_rd_en", 64'(rd_en), 64'd0);
                for (int c = 0; c < 6; c++) begin
                    if (wr_en) j_post_wr++;
                    if (done) j_post_done++;
                    @(negedge clk);
                end
                j_aborted = 1;
                fin = 1;
            end
            if (!fin) begin
                @(negedge clk);
                k++;
                start = (k == spur_at);
                if (k == spur_at) mode = 8'h00;
            end
        end
        start = 1'b0;
        chk("job_end", 64'(fin), 64'd1);
    endtask

    logic [7:0] m1, m2;
    int l1, last1;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_mode", 64'(rop_Mode), 64'd0);
        rst = 1'b0;

        // Length 4 SRCCOPY
        for (int i = 0; i < W; i++) begin
            pm[i] = $urandom;
            sm[i] = 32'hA5A5_0000 + i;
            dn[i] = '0;
        end
        preload();
        run_job(ROP_SRCCOPY, 9'd4, -1, -1);
        chk("l4_busy", 64'(j_busy), 64'd8);
        chk("l4_done_at", 64'(j_done_at), 64'd8);
        chk("l4_first_wr", 64'(j_first_wr), 64'd4);
        chk("l4_last_wr", 64'(j_last_wr), 64'd7);
        chk("l4_wr", 64'(j_wr), 64'd4);
        chk("l4_order", 64'(j_order), 64'd0);
        for (int i = 0; i < 4; i++) chk("l4_d", 64'(dm[i]), 64'(32'hA5A5_0000 + i));
        golden(ROP_SRCCOPY, 4);
        chk_mem("l4_mem");

        // Zero length
        run_job(ROP_WHITENESS, 9'd0, -1, -1);
        chk("z_busy", 64'(j_busy), 64'd1);
        chk("z_done_at", 64'(j_done_at), 64'd1);
        chk("z_done_busy", 64'(j_done_busy), 64'd1);
        chk("z_rd", 64'(j_rd), 64'd0);
        chk("z_wr", 64'(j_wr), 64'd0);
        chk_mem("z_mem");

        // Full span SRCINVERT
        for (int i = 0; i < W; i++) begin
            pm[i] = '0;
            sm[i] = 32'hFFFF_0000;
            dn[i] = 32'h0F0F_0F0F;
        end
        preload();
        run_job(ROP_SRCINVERT, 9'h100, -1, -1);
        chk("fs_busy", 64'(j_busy), 64'd260);
        chk("fs_wr", 64'(j_wr), 64'd256);
        chk("fs_rd", 64'(j_rd), 64'd256);
        chk("fs_order", 64'(j_order), 64'd0);
        chk("fs_d255", 64'(dm[255]), 64'(32'hF0F0_0F0F));
        golden(ROP_SRCINVERT, 256);
        chk_mem("fs_mem");

        // Start while busy is ignored
        fill_rand();
        l1 = $urandom_range(6, 20);
        run_job(ROP_SRCCOPY, (AW+1)'(l1), 3, -1);
        chk("sp_wr", 64'(j_wr), 64'(l1));
        chk("sp_mode_bad", 64'(j_mode_bad), 64'd0);
        chk("sp_mode", 64'(rop_Mode), 64'(ROP_SRCCOPY));
        chk("sp_busy", 64'(j_busy), 64'(l1 + 4));
        golden(ROP_SRCCOPY, l1);
        chk_mem("sp_mem");

        // Reset mid-job on the sixth read
        fill_rand();
        m1 = 8'($urandom);
        run_job(m1, 9'd16, -1, 5);
        chk("ab_aborted", 64'(j_aborted), 64'd1);
        chk("ab_wr", 64'(j_wr), 64'd3);
        chk("ab_post_wr", 64'(j_post_wr), 64'd0);
        chk("ab_post_done", 64'(j_post_done), 64'd0);
        chk("ab_done", 64'(j_done), 64'd0);
        golden(m1, 3);
        chk_mem("ab_mem");
        m2 = 8'($urandom);
        run_job(m2, 9'd2, -1, -1);
        chk("ab2_done_at", 64'(j_done_at), 64'd6);
        chk("ab2_wr", 64'(j_wr), 64'd2);
        golden(m2, 2);
        chk_mem("ab2_mem");

        // Back-to-back jobs
        fill_rand();
        m1 = 8'($urandom);
        l1 = $urandom_range(4, 12);
        run_job(m1, (AW+1)'(l1), -1, -1);
        last1 = j_last_wr_abs;
        chk("bb1_wr", 64'(j_wr), 64'(l1));
        run_job(ROP_DSTINVERT, 9'd3, -1, -1);
        chk("bb_gap", 64'(j_first_rd_abs - last1), 64'd3);
        chk("bb2_wr", 64'(j_wr), 64'd3);
        golden(m1, l1);
        golden(ROP_DSTINVERT, 3);
        chk_mem("bb_mem");

        // A few random jobs
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            m1 = 8'($urandom);
            l1 = $urandom_range(1, 40);
            run_job(m1, (AW+1)'(l1), -1, -1);
            chk("rj_busy", 64'(j_busy), 64'(l1 + 4));
            chk("rj_wr", 64'(j_wr), 64'(l1));
            chk("rj_order", 64'(j_order), 64'd0);
            golden(m1, l1);
            chk_mem("rj_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
